// File: rtl/updn_cmd_gen.sv
// updn_cmd_gen
//   Turns three raw push-buttons into single-cycle commands for a downstream
//   5-bit up/down counter. Every button goes through a 2-flop synchronizer
//   and a debouncer. A debounced press raises a pending flag. One pending
//   flag is granted per cycle, with priority load > down > up. An up or down
//   command that would push a saturated counter further is dropped, and
//   sat_err pulses instead.
//
//   Optional feature (macro AUTO_REPEAT_EN): btn_up and btn_down each get an
//   IDLE/HOLD/REPEAT repeat FSM. btn_load never repeats.
//
// Parameters
//   DEB_CYCLES  consecutive disagreeing samples needed to flip a debounced state
//   REP_DELAY   held cycles after the first pulse before auto-repeat starts
//   REP_PERIOD  cycles between auto-repeat pulses
//
// Ports
//   clk                          rising-edge clock
//   rst_n                        asynchronous active-low reset
//   btn_up, btn_down, btn_load   raw asynchronous button levels, active-high
//   load_val[4:0]                value to load into the counter
//   high, low                    saturation flags from the counter
//   cnt_in[4:0]                  registered load value (captured when load fires)
//   load, up, down               registered one-cycle command pulses
//   sat_err                      one-cycle pulse when up/down is dropped on saturation
module updn_cmd_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int REP_DELAY  = 16,
  parameter int REP_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [4:0] load_val,
  input  logic       high,
  input  logic       low,
  output logic [4:0] cnt_in,
  output logic       load,
  output logic       up,
  output logic       down,
  output logic       sat_err
);

  // Button index map: 0 = up, 1 = down, 2 = load
  localparam int NB = 3;
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_reg, sync2_reg;
  logic [NB-1:0] deb_state;
  logic [NB-1:0] deb_prev_reg;
  logic [NB-1:0] rise;
  logic [NB-1:0] rep_set;
  logic [NB-1:0] pend_reg, pend_next;
  logic [NB-1:0] gnt;

  assign btn_raw = {btn_load, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      deb_prev_reg <= '0;
    end else begin
      sync1_reg    <= btn_raw;
      sync2_reg    <= sync1_reg;
      deb_prev_reg <= deb_state;
    end
  end

  // Debouncer per button. Any sample that agrees with the current state
  // restarts the count.
  for (genvar gi = 0; gi < NB; gi++) begin : g_deb
    logic [DW-1:0] cnt_reg;
    logic          deb_bit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg     <= '0;
        deb_bit_reg <= 1'b0;
      end else if (sync2_reg[gi] != deb_bit_reg) begin
        if (cnt_reg == DW'(DEB_CYCLES - 1)) begin
          cnt_reg     <= '0;
          deb_bit_reg <= ~deb_bit_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end

    assign deb_state[gi] = deb_bit_reg;
  end

  // Only debounced press edges create commands. Release edges are ignored.
  assign rise = deb_state & ~deb_prev_reg;

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int TW      = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rep
    rep_state_t    state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          fire;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= IDLE;
        timer_reg <= '0;
      end else begin
        state_reg <= state_next;
        timer_reg <= timer_next;
      end
    end

    // HOLD starts on the same edge that sets the first pending flag. The
    // timer therefore lines up repeat pulses REP_DELAY cycles after the
    // first pulse, and then every REP_PERIOD cycles.
    always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      fire       = 1'b0;
      case (state_reg)
        IDLE: begin
          if (rise[gi]) begin
            state_next = HOLD;
            timer_next = '0;
          end
        end
        HOLD: begin
          if (!deb_state[gi]) begin
            state_next = IDLE;
          end else if (timer_reg == TW'(REP_DELAY - 1)) begin
            state_next = REPEAT;
            timer_next = '0;
            fire       = 1'b1;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        REPEAT: begin
          if (!deb_state[gi]) begin
            state_next = IDLE;
          end else if (timer_reg == TW'(REP_PERIOD - 1)) begin
            timer_next = '0;
            fire       = 1'b1;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    assign rep_set[gi] = fire;
  end
  assign rep_set[2] = 1'b0;
`else
  assign rep_set = '0;
`endif

  // Fixed-priority grant. A granted flag clears whether or not it produces a
  // pulse. A new press on an already-pending button simply re-sets the flag,
  // so repeated presses are not counted.
  always_comb begin
    gnt       = '0;
    gnt[2]    = pend_reg[2];
    gnt[1]    = pend_reg[1] & ~pend_reg[2];
    gnt[0]    = pend_reg[0] & ~pend_reg[2] & ~pend_reg[1];
    pend_next = (pend_reg & ~gnt) | rise | rep_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      cnt_in   <= '0;
      load     <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      sat_err  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      load     <= gnt[2];
      down     <= gnt[1] & ~low;
      up       <= gnt[0] & ~high;
      sat_err  <= (gnt[1] & low) | (gnt[0] & high);
      if (gnt[2]) begin
        cnt_in <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_updn_cmd_gen.sv
// Testbench for updn_cmd_gen. Table-driven press vectors feed a per-cycle
// scoreboard queue. Hand-written sequences cover reset during debounce.
module tb_updn_cmd_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0;
  logic [4:0] load_val = '0;
  logic       high = 1'b0, low = 1'b0;
  logic [4:0] cnt_in;
  logic       load, up, down, sat_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  updn_cmd_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .load_val (load_val),
    .high     (high),
    .low      (low),
    .cnt_in   (cnt_in),
    .load     (load),
    .up       (up),
    .down     (down),
    .sat_err  (sat_err)
  );

  localparam int WIN = 60;

  // Bit k of each mask means the output is high after rising edge k.
  // Edge 0 is the first edge that samples the raw buttons high.
  typedef struct {
    string       name;
    logic        bu, bd, bl;
    int          hold;
    logic [4:0]  lval;
    logic        hi, lo;
    logic [63:0] ld_m, up_m, dn_m, se_m;
  } vec_t;

  vec_t vecs[9];
  logic [8:0] sb_q[$];   // {load, up, down, sat_err, cnt_in}

  function automatic logic [63:0] bit_at(int k);
    logic [63:0] m;
    m = 64'd1;
    return m << k;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {load, up, down, sat_err, cnt_in}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(int vi);
    vec_t v;
    int   ld_at;
    int   npress;
    v = vecs[vi];
    do_reset();
    load_val = v.lval;
    high     = v.hi;
    low      = v.lo;
    ld_at    = -1;
    for (int k = WIN - 1; k >= 0; k--)
      if (v.ld_m[k]) ld_at = k;
    // Push the expected output word for every cycle of the window.
    for (int k = 0; k < WIN; k++) begin
      logic [4:0] ec;
      ec = (ld_at >= 0 && k >= ld_at) ? v.lval : 5'd0;
      sb_q.push_back({v.ld_m[k], v.up_m[k], v.dn_m[k], v.se_m[k], ec});
    end
    btn_up   = v.bu;
    btn_down = v.bd;
    btn_load = v.bl;
    npress   = 0;
    for (int k = 0; k < WIN; k++) begin
      logic [8:0] e;
      logic [8:0] a;
      if (k == v.hold) begin
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_load = 1'b0;
      end
      @(posedge clk);
      #1;
      a = {load, up, down, sat_err, cnt_in};
      if (sb_q.size() == 0) begin
        check($sformatf("%s_sb_empty_c%0d", v.name, k), 0, 1);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s_c%0d", v.name, k), a, e);
      end
      npress += int'(load) + int'(up) + int'(down) + int'(sat_err);
    end
    $display("[TB] vector %s: %0d output pulses seen", v.name, npress);
  endtask

  initial begin
    logic [63:0] up_rep, dn_rep;
    int pulses;

    up_rep = '0;
    dn_rep = '0;
`ifdef AUTO_REPEAT_EN
    // A 20-cycle hold reaches the first repeat pulse before release lands.
    up_rep = bit_at(23);
    for (int k = 23; k <= 43; k += 4) dn_rep |= bit_at(k);
`endif

    vecs[0] = '{"up_single",   1,0,0, 20, 5'd0,  0,0, '0, bit_at(7) | up_rep, '0, '0};
    vecs[1] = '{"up_glitch",   1,0,0,  3, 5'd0,  0,0, '0, '0, '0, '0};
    vecs[2] = '{"all_three",   1,1,1, 12, 5'd5,  0,0, bit_at(7), bit_at(9), bit_at(8), '0};
    vecs[3] = '{"up_sat",      1,0,0, 12, 5'd0,  1,0, '0, '0, '0, bit_at(7)};
    vecs[4] = '{"down_sat",    0,1,0, 12, 5'd0,  0,1, '0, '0, '0, bit_at(7)};
    vecs[5] = '{"down_single", 0,1,0, 12, 5'd0,  0,0, '0, '0, bit_at(7), '0};
    vecs[6] = '{"load_max",    0,0,1, 12, 5'd31, 0,0, bit_at(7), '0, '0, '0};
    vecs[7] = '{"down_hi_ok",  0,1,0, 12, 5'd0,  1,0, '0, '0, bit_at(7), '0};
    vecs[8] = '{"down_rep40",  0,1,0, 40, 5'd0,  0,0, '0, '0, bit_at(7) | dn_rep, '0};

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset during debounce must clear outputs at once (including a held
    // cnt_in) and drop the aborted press.
    do_reset();
    load_val = 5'd9;
    btn_load = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("seq_load_cnt", cnt_in, 9);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("seq_async_reset_outs", {load, up, down, sat_err, cnt_in}, 0);
    btn_up = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      pulses += int'(up) + int'(load) + int'(down) + int'(sat_err);
    end
    check("seq_aborted_press_no_cmd", pulses, 0);
    $display("[TB] seq reset-abort: %0d pulses after reset", pulses);

    // A button still held when reset releases counts as a fresh press.
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("seq_held_thru_reset_c%0d", k), up, (k == 7) ? 1 : 0);
    end
    btn_up = 1'b0;
    $display("[TB] seq held-through-reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updn_cmd_gen.md
UPDN_CMD_GEN -- requirements
Module: updn_cmd_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 4: number of consecutive stable synchronized samples required before a debounced button state changes.
REQ-002 Parameter REP_DELAY, default 16: cycles a button must stay held after its first pulse before auto-repeat starts.
REQ-003 Parameter REP_PERIOD, default 4: cycles between successive auto-repeat pulses.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_up / btn_down / btn_load  input  1 each  raw asynchronous push-button levels, active-high.
REQ-007 load_val  input  5  value to be loaded into the downstream counter.
REQ-008 high / low  input  1 each  saturation flags fed back from the downstream up/down counter.
REQ-009 cnt_in  output  5  registered load value driven to the counter's in port.
REQ-010 load / up / down  output  1 each  registered single-cycle command pulses to the counter.
REQ-011 sat_err  output  1  single-cycle pulse when a command is dropped because of saturation.

Function
REQ-012 Each btn_* input SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each debounced state SHALL toggle only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any intervening agreeing sample restarts the count.
REQ-014 A debounced 0->1 transition SHALL set that button's pending flag; 1->0 transitions SHALL produce no command.
REQ-015 Latency: with no contention, a command pulse SHALL be high for exactly the cycle following edge DEB_CYCLES+3, where edge 0 is the first edge that samples the raw button high.
REQ-016 At most one of load/up/down SHALL be high in any cycle; priority is load > down > up.
REQ-017 A lower-priority pending flag SHALL survive a loss in arbitration and issue in a later cycle; simultaneous load+down+up presses SHALL therefore issue load, down, up on three consecutive cycles.
REQ-018 cnt_in SHALL capture load_val on the edge that asserts load, and hold that value until the next load.
REQ-019 A pending up SHALL be cleared without a pulse when it wins arbitration while high=1.
REQ-020 A pending down SHALL be cleared without a pulse when it wins arbitration while low=1.
REQ-021 Every such drop (REQ-019, REQ-020) SHALL pulse sat_err for one cycle.
REQ-022 A new edge on a button whose pending flag is already set SHALL be absorbed; no counting of multiple presses.

Reset
REQ-023 rst_n low SHALL immediately clear the synchronizers, debounce counters, debounced states, pending flags and repeat FSMs.
REQ-024 rst_n low SHALL immediately force cnt_in=0, load=0, up=0, down=0 and sat_err=0.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL discard the partial operation; a button still held at release SHALL be treated as a new press.

Configuration
REQ-026 With macro AUTO_REPEAT_EN defined, btn_up and btn_down SHALL each have a repeat FSM with states IDLE, HOLD and REPEAT.
REQ-027 IDLE->HOLD SHALL occur on the first pulse; HOLD->REPEAT SHALL occur after REP_DELAY held cycles; in REPEAT, pending SHALL be set every REP_PERIOD cycles; any state SHALL return to IDLE on debounced release.
REQ-028 Without AUTO_REPEAT_EN, no repeat FSM SHALL be built and each press SHALL yield exactly one command.
REQ-029 btn_load SHALL never auto-repeat, with or without AUTO_REPEAT_EN.

Verification
REQ-030 btn_up raised at edge 0 and held 20 cycles, high=0, low=0 -> single up pulse in the cycle after edge 7, no other command pulse.
REQ-031 btn_up glitch high for 3 cycles -> no up pulse.
REQ-032 btn_load, btn_down and btn_up raised together, load_val=5'b00101, high=0, low=0 -> load, down, up on consecutive cycles, and cnt_in=5'b00101 from the load cycle.
REQ-033 btn_up press with high=1 -> no up pulse and one sat_err pulse.
REQ-034 btn_down press with low=1 -> no down pulse and one sat_err pulse.
REQ-035 AUTO_REPEAT_EN defined, btn_down held 40 cycles with low=0 -> first pulse, then repeat pulses every 4 cycles starting 16 cycles after the first pulse.
REQ-036 rst_n pulsed low mid-debounce -> all outputs 0 immediately, and no command from the aborted press.
